// File: rtl/mul_seq_32.sv
// mul_seq_32: multi-cycle shift-add multiplier.
//
// Each operation takes WIDTH EXEC cycles followed by one DONE cycle. Signed
// operands are turned into magnitudes on entry, and the sign is applied to the
// product in DONE.
//
// Handshake: op_start is a one-cycle request. It is accepted only in IDLE and
// only when op_clear is low. op_done is a registered one-cycle pulse. The new
// result_hi/result_lo are valid in the same cycle that op_done is high.
// Requests made while busy or in DONE are dropped, not queued.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   op_start     start request (sampled in IDLE)
//   op_clear     synchronous clear of FSM and results (wins over op_start)
//   is_signed    1 = two's-complement operands (sampled with op_start)
//   multiplicand operand A
//   multiplier   operand B
//   result_lo    product bits [WIDTH-1:0]
//   result_hi    product bits [2*WIDTH-1:WIDTH]
//   busy         high while iterating (EXEC)
//   op_done      one-cycle pulse when results update
module mul_seq_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             op_done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // multiplier bits, with the low product bits shifted in
    logic [WIDTH-1:0] acc_hi;
    logic             neg_flag;

    logic             last_iter;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [2*WIDTH-1:0] product_mag;
    logic [2*WIDTH-1:0] product;

    assign last_iter = (counter == CW'(WIDTH - 1));
    assign busy      = (state == EXEC);

    // Magnitudes. The most-negative value maps to itself, which is the
    // correct unsigned magnitude.
    assign a_abs = (is_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign b_abs = (is_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;

    // Conditional add into the upper half. The carry is kept in sum[WIDTH].
    assign sum = {1'b0, acc_hi} + (b_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});

    assign product_mag = {acc_hi, b_reg};
    assign product     = neg_flag ? -product_mag : product_mag;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (op_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (op_start) state_nxt = EXEC;
                EXEC:    if (last_iter) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_hi    <= '0;
            neg_flag  <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            op_done   <= 1'b0;
        end else if (op_clear) begin
            counter   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_hi    <= '0;
            neg_flag  <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            op_done   <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_start) begin
                        a_reg    <= a_abs;
                        b_reg    <= b_abs;
                        acc_hi   <= '0;
                        counter  <= '0;
                        neg_flag <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    end
                end
                EXEC: begin
                    // Shift {carry, acc_hi, b_reg} right by one.
                    acc_hi  <= sum[WIDTH:1];
                    b_reg   <= {sum[0], b_reg[WIDTH-1:1]};
                    counter <= counter + CW'(1);
                end
                DONE: begin
                    result_hi <= product[2*WIDTH-1:WIDTH];
                    result_lo <= product[WIDTH-1:0];
                    op_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_32.sv
module tb_mul_seq_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        op_clear;
    logic        is_signed;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        busy;
    logic        op_done;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[10];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    mul_seq_32 dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .busy         (busy),
        .op_done      (op_done)
    );

    // reference model: plain 64-bit arithmetic
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
            return 64'(pa * pb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Starts an operation at a negedge and returns at the negedge where op_done
    // is seen (or after 60 edges). A nonzero inj_edge makes the task also drive
    // a second request (9*9) that is sampled at that edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int inj_edge, output logic [63:0] prod,
                          output int lat, output int busy_cyc, output bit changed);
        logic [63:0] prev;
        prev         = {result_hi, result_lo};
        changed      = 1'b0;
        lat          = 0;
        prod         = 'x;
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        op_start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_start = 1'b0;
        busy_cyc = busy ? 1 : 0;
        if ({result_hi, result_lo} !== prev) changed = 1'b1;
        while (lat < 60) begin
            if (inj_edge != 0 && lat == inj_edge - 1) begin
                multiplicand = 32'd9;
                multiplier   = 32'd9;
                op_start     = 1'b1;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            op_start = 1'b0;
            if (busy) busy_cyc++;
            if (op_done) begin
                prod = {result_hi, result_lo};
                break;
            end
            if ({result_hi, result_lo} !== prev) changed = 1'b1;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (op_done) n++;
        end
    endtask

    initial begin
        logic [63:0] prod;
        logic [63:0] exp;
        int lat, bc, nd;
        bit chg;
        logic [31:0] ra, rb;
        logic rs;

        tbl[0] = '{32'd7,        32'd6,        1'b0, 64'h00000000_0000002A};
        tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        tbl[2] = '{32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFFFFFF_FFFFFFF1};
        tbl[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        tbl[4] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC0000000_80000000};
        tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
        tbl[6] = '{32'h80000000, 32'd2,        1'b0, 64'h00000001_00000000};
        tbl[7] = '{32'd0,        32'hDEADBEEF, 1'b0, 64'h00000000_00000000};
        tbl[8] = '{32'd1,        32'h89ABCDEF, 1'b1, 64'hFFFFFFFF_89ABCDEF};
        tbl[9] = '{32'hFFFFFFFF, 32'd1,        1'b0, 64'h00000000_FFFFFFFF};

        reset = 1'b1; op_start = 1'b0; op_clear = 1'b0; is_signed = 1'b0;
        multiplicand = '0; multiplier = '0;
        #1;
        check("rst_result", {result_hi, result_lo}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(op_done), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, 0, prod, lat, bc, chg);
            check($sformatf("tbl%0d_prod", i), prod, tbl[i].exp);
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'd33);
            check($sformatf("tbl%0d_busy", i), 64'(bc), 64'd32);
            check($sformatf("tbl%0d_hold", i), 64'(chg), 64'd0);
            @(negedge clk);
            check($sformatf("tbl%0d_pulse", i), 64'(op_done), 64'd0);
        end

        // request while busy is dropped
        run_op(32'd3, 32'd4, 1'b0, 10, prod, lat, bc, chg);
        check("busy_req_prod", prod, 64'd12);
        check("busy_req_lat", 64'(lat), 64'd33);
        count_done(45, nd);
        check("busy_req_extra_done", 64'(nd), 64'd0);

        // asynchronous reset mid-operation
        multiplicand = 32'd2; multiplier = 32'd2; is_signed = 1'b0; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (15) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_result", {result_hi, result_lo}, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(45, nd);
        check("arst_no_done", 64'(nd), 64'd0);
        run_op(32'd2, 32'd2, 1'b0, 0, prod, lat, bc, chg);
        check("arst_restart_prod", prod, 64'd4);
        check("arst_restart_lat", 64'(lat), 64'd33);

        // synchronous clear mid-operation
        @(negedge clk);
        multiplicand = 32'd5; multiplier = 32'd5; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (14) @(negedge clk);
        op_clear = 1'b1;
        #1;
        check("clr_before_edge", {result_hi, result_lo}, 64'd4);
        @(negedge clk);
        op_clear = 1'b0;
        check("clr_result", {result_hi, result_lo}, 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        count_done(45, nd);
        check("clr_no_done", 64'(nd), 64'd0);
        run_op(32'd3, 32'd3, 1'b0, 0, prod, lat, bc, chg);
        check("clr_restart_prod", prod, 64'd9);
        check("clr_restart_lat", 64'(lat), 64'd33);

        // back-to-back: new start in the op_done cycle, old result held
        run_op(32'd0, 32'h12345678, 1'b0, 0, prod, lat, bc, chg);
        check("b2b_prod", prod, 64'd0);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_hold", 64'(chg), 64'd0);

        // op_clear and op_start together: clear wins
        @(negedge clk);
        multiplicand = 32'd5; multiplier = 32'd7; op_start = 1'b1; op_clear = 1'b1;
        @(negedge clk);
        op_start = 1'b0; op_clear = 1'b0;
        check("clr_start_busy", 64'(busy), 64'd0);
        count_done(40, nd);
        check("clr_start_no_done", 64'(nd), 64'd0);

        // randomized operations against the reference model
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i == 0) ra = 32'h80000000;
            exp_q.push_back(ref_mul(ra, rb, rs));
            run_op(ra, rb, rs, 0, prod, lat, bc, chg);
            exp = exp_q.pop_front();
            check($sformatf("rnd%0d_prod a=%h b=%h s=%0d", i, ra, rb, rs), prod, exp);
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'd33);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_32.md
Name: mul_seq_32

Overview:
- Multi-cycle shift-add multiplier for the arithmetic & logical computing system.
- Sits directly upstream of the 32-bit 6-to-1 result select mux.
- result_lo and result_hi drive two of its data inputs.
- The controller starts it with a one-cycle op_start and selects its outputs once op_done pulses.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH split into result_hi/result_lo.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
op_start  input  1  one-cycle request; sampled only in IDLE
op_clear  input  1  synchronous clear of results and FSM
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with op_start
multiplicand  input  WIDTH  operand A; sampled with op_start
multiplier  input  WIDTH  operand B; sampled with op_start
result_lo  output  WIDTH  product bits [WIDTH-1:0]
result_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
busy  output  1  high in EXEC
op_done  output  1  one-cycle pulse when result becomes valid

Behaviour:
- Reset (async, active-high): state=IDLE, result_lo=0, result_hi=0, busy=0, op_done=0, counter=0, operand registers=0. A reset during EXEC aborts the operation; no op_done follows.
- States:
  - IDLE: if op_start=1, latch operands and is_signed, clear accumulator, counter=0, go to EXEC.
    - Signed mode: latch magnitudes |A|, |B| and neg_flag = A[W-1]^B[W-1].
    - Unsigned mode: neg_flag=0.
  - EXEC, one iteration per cycle:
    - if B_reg[0]=1, add A_reg into the upper WIDTH bits with carry (WIDTH+1-bit sum);
    - shift {carry, acc_hi, acc_lo/B_reg} right by 1;
    - increment counter.
    - After the WIDTH-th iteration go to DONE.
  - DONE: for exactly one cycle, write the product (two's-complement negated if neg_flag) to result_hi/result_lo, assert op_done=1, then return to IDLE.
- Latency: op_start sampled at edge 0; EXEC occupies edges 1..WIDTH; result_* and op_done are valid after edge WIDTH+1 (33 for WIDTH=32).
- busy=1 from the edge after op_start through the last EXEC cycle; 0 in IDLE and DONE.
- result_lo/result_hi hold their last value until the next DONE, op_clear or reset. They do not change during EXEC; the accumulator is internal.
- op_start while busy or in DONE: ignored, no queueing.
- op_start and op_clear in the same cycle: op_clear wins, state stays IDLE.
- op_clear in any state: next edge gives IDLE, results=0, op_done=0, busy=0; any in-flight operation is discarded.
- Signed magnitude of the most-negative value (0x80000000) is 0x80000000 as unsigned; no overflow handling needed, because the 2*WIDTH product always fits.
- Zero operand: full WIDTH iterations still run; latency is constant, with no early termination.
- op_done is registered and has no combinational path from inputs.

Test Plan:
1. Reset, then op_start with A=7, B=6, is_signed=0.
   -> busy=1 for 32 cycles; op_done pulses once at edge 33; result_hi=0x00000000, result_lo=0x0000002A.
2. Unsigned A=0xFFFFFFFF, B=0xFFFFFFFF.
   -> result_hi=0xFFFFFFFE, result_lo=0x00000001.
3. Signed cases:
   - A=0xFFFFFFFD (-3), B=5 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1 (-15).
   - A=B=0x80000000 -> result_hi=0x40000000, result_lo=0x00000000.
4. Start A=3, B=4; at edge 10 assert op_start with A=9, B=9.
   -> second request ignored; result_lo=0x0000000C at edge 33; only one op_done pulse.
5. Mid-operation aborts:
   - Start A=2, B=2; assert reset asynchronously at cycle 15 -> outputs immediately 0, state IDLE, no op_done. Repeat with op_clear instead of reset -> same outcome, taking effect at the next edge.
   - A new op_start after either abort -> completes normally in 33 cycles.
6. Back-to-back: op_start again in the cycle after op_done with A=0, B=0x12345678.
   -> accepted; previous result held during EXEC; new result_hi=result_lo=0 at edge 33.
